cde_sync_filter: RTL and testbench
==================================

Name: cde_sync_filter

Overview:
- Multi-channel input conditioner for asynchronous level signals such as pins, straps and cross-domain status bits.
- Each channel passes through a DEPTH-stage synchronizer and then a glitch/debounce filter. A new level is accepted only after it has been stable for FILTER qualifying cycles.
- Each channel also produces registered single-cycle rise and fall pulses.
- Sits between pad/async sources and core control logic in a single clock domain.

Parameters:
- WIDTH, 1: number of independent channels.
- DEPTH, 2: synchronizer flop stages per channel; legal range 2..8.
- FILTER, 4: qualifying stable cycles needed to accept a new level; legal range 1..65535.
- RST_VAL, {WIDTH{1'b0}}: per-channel reset value of the sync stages and the filtered output.

Ports:
- clk  input  1  sole clock.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  filter qualification strobe; tie to 1 for per-clock filtering.
- data_in  input  WIDTH  asynchronous channel inputs.
- data_out  output  WIDTH  filtered, synchronized levels.
- rise  output  WIDTH  one-cycle pulse when a channel's data_out goes 0->1.
- fall  output  WIDTH  one-cycle pulse when a channel's data_out goes 1->0.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset:
  - Applies on any clk rising edge with reset=1, and overrides all other activity.
  - All sync stages load RST_VAL and data_out=RST_VAL.
  - All counters load 0; rise=0, fall=0.
  - Reset asserted mid-count discards the partial count. No pulse is generated by reset itself.
- Synchronizer:
  - Per channel, s[1] <= data_in, s[k] <= s[k-1]; the chain always shifts, independent of tick.
  - sy = s[DEPTH].
- Filter state per channel:
  - data_out bit f.
  - Counter cnt, width $clog2(FILTER+1), minimum 1 bit.
- Filter update each non-reset edge, per channel i:
  - If sy[i]==f[i]: cnt<=0 (the counter clears regardless of tick).
  - Else if tick==0: cnt holds.
  - Else if cnt==FILTER-1: f<=sy[i], cnt<=0, and the matching rise[i] or fall[i] pulses.
  - Else: cnt<=cnt+1.
- Glitches: any return of sy to f before acceptance clears the count. A glitch shorter than FILTER qualifying cycles never reaches data_out.
- Pulses:
  - rise/fall are registered and asserted in the same cycle data_out takes its new value.
  - Deasserted on the next edge unless another acceptance occurs. Back-to-back acceptances are not possible for FILTER>=1 with a stable source.
  - rise[i] and fall[i] are never high together.
- Latency with tick=1:
  - data_in stable before edge E -> sy changes after edge E+DEPTH-1 -> data_out, rise/fall change at edge E+DEPTH-1+FILTER.
  - DEPTH=2, FILTER=1 gives 2 cycles, matching a plain 2-flop synchronizer plus one registered stage.
- Latency with gated tick: the acceptance edge is the FILTER-th edge with tick=1 while sy differs from f, counted continuously.
- Channels are fully independent; no shared state.
- Counter never exceeds FILTER-1, so no wrap-around is possible.
- No combinational path from any input to any output.

Test Plan:
- Reset values: WIDTH=4, RST_VAL=4'b1010, reset held 3 cycles with data_in=4'b0101 -> data_out=4'b1010, rise=fall=0 throughout. First release edge starts the sync chain; no pulses before DEPTH+FILTER edges.
- Nominal latency: DEPTH=2, FILTER=4, tick=1, data_in[0] 0->1 before edge E -> data_out[0]=1 and rise[0]=1 for exactly one cycle at edge E+5; fall=0.
- Glitch rejection: FILTER=4, data_in[0] high for 3 cycles then low -> data_out[0] stays 0, no rise. High for 4 cycles -> accepted, rise pulse, then fall pulse 4 cycles after sy returns low.
- Tick gating: FILTER=3, tick high every 4th cycle, sy changes -> acceptance on the 3rd tick edge. A mismatch gap between ticks with sy reverting clears cnt; after the next change, counting restarts from 0.
- Reset mid-operation: FILTER=8, assert reset when cnt=6 -> data_out=RST_VAL, no pulse. After release, a sustained input is accepted only after a full DEPTH+8 edges.
- Channel independence: WIDTH=8, toggle channels 0 and 5 simultaneously and channel 3 offset by 2 cycles -> per-channel pulses at their own latencies; untouched channels show no activity.

Source files
------------

// File: rtl/cde_sync_filter.sv
// -----------------------------------------------------------------------------
// cde_sync_filter
//
// Multi-channel input conditioner for asynchronous level signals (pins,
// straps, cross-domain status bits). Every channel is handled the same way:
//
//   data_in -> DEPTH-flop synchronizer -> stability filter -> data_out
//                                                         -> rise / fall
//
// The synchronized level (sy) must differ from the current filtered level for
// FILTER qualifying cycles (edges with tick=1) in a row before it is accepted.
// If sy returns to the filtered level at any point, the partial count is
// dropped, so a glitch shorter than FILTER qualifying cycles is never seen
// downstream. A one-cycle rise or fall pulse is registered on the same edge
// that data_out takes its new value.
//
// Parameters
//   WIDTH   : number of independent channels
//   DEPTH   : synchronizer stages per channel (2..8)
//   FILTER  : qualifying stable cycles needed to accept a new level (1..65535)
//   RST_VAL : per-channel reset value of sync stages and data_out
//
// Ports
//   clk      : sole clock
//   reset    : synchronous, active-high reset; overrides everything else
//   tick     : filter qualification strobe (tie high for per-clock filtering)
//   data_in  : [WIDTH] asynchronous channel inputs
//   data_out : [WIDTH] filtered, synchronized levels
//   rise     : [WIDTH] one-cycle pulse when data_out goes 0->1
//   fall     : [WIDTH] one-cycle pulse when data_out goes 1->0
//
// Every output comes straight from a flop; there is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module cde_sync_filter #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter int               FILTER  = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    // Counter holds 0..FILTER-1; sized from FILTER+1 so it is always at least
    // one bit wide (FILTER=1 only ever uses the value 0).
    localparam int CW = ($clog2(FILTER + 1) < 1) ? 1 : $clog2(FILTER + 1);

    // Terminal count: the FILTER-th qualifying mismatch edge is the one that
    // sees cnt == FILTER-1, so acceptance never lets the counter wrap.
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            // sync_reg[0] is the first capture flop, sync_reg[DEPTH-1] feeds
            // the filter.
            logic [DEPTH-1:0] sync_reg;
            logic             sy;

            logic             filt_reg;
            logic             filt_next;
            logic [CW-1:0]    cnt_reg;
            logic [CW-1:0]    cnt_next;
            logic             rise_reg;
            logic             rise_next;
            logic             fall_reg;
            logic             fall_next;

            assign sy = sync_reg[DEPTH-1];

            // Filter next-state. The counter clears whenever sy agrees with
            // the filtered level, independent of tick, so any reversion
            // during a gap between ticks still discards the partial count.
            always_comb begin
                filt_next = filt_reg;
                cnt_next  = cnt_reg;
                rise_next = 1'b0;
                fall_next = 1'b0;

                if (sy == filt_reg) begin
                    cnt_next = '0;
                end else if (!tick) begin
                    cnt_next = cnt_reg;
                end else if (cnt_reg == CNT_LAST) begin
                    filt_next = sy;
                    cnt_next  = '0;
                    rise_next = sy;
                    fall_next = ~sy;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    // Reset loads the filtered level directly, so it never
                    // produces an edge pulse of its own.
                    sync_reg <= {DEPTH{RST_VAL[gi]}};
                    filt_reg <= RST_VAL[gi];
                    cnt_reg  <= '0;
                    rise_reg <= 1'b0;
                    fall_reg <= 1'b0;
                end else begin
                    // The synchronizer shifts every clock; tick only gates
                    // the filter counter.
                    sync_reg <= {sync_reg[DEPTH-2:0], data_in[gi]};
                    filt_reg <= filt_next;
                    cnt_reg  <= cnt_next;
                    rise_reg <= rise_next;
                    fall_reg <= fall_next;
                end
            end

            assign data_out[gi] = filt_reg;
            assign rise[gi]     = rise_reg;
            assign fall[gi]     = fall_reg;
        end
    endgenerate

endmodule

// File: tb/tb_cde_sync_filter.sv
// -----------------------------------------------------------------------------
// Testbench for cde_sync_filter (WIDTH=8, DEPTH=2, FILTER=4, RST_VAL=8'hC2).
// Table-driven vectors for reset, latency, glitch rejection and tick gating,
// hand-written sequences for reset mid-count and channel independence, then
// randomized stimulus against a reference model built from the acceptance
// rules using a history queue and per-channel integer run counts.
// -----------------------------------------------------------------------------
module tb_cde_sync_filter;

    localparam int         W   = 8;
    localparam int         D   = 2;
    localparam int         F   = 4;
    localparam logic [7:0] RV  = 8'hC2;

    logic         clk = 1'b0;
    logic         reset;
    logic         tick;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;

    int checks = 0;
    int errors = 0;

    cde_sync_filter #(
        .WIDTH  (W),
        .DEPTH  (D),
        .FILTER (F),
        .RST_VAL(RV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .data_in (data_in),
        .data_out(data_out),
        .rise    (rise),
        .fall    (fall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // hist holds the data_in words seen on past edges, oldest first; the
    // oldest is what the filter sees as its synchronized input this edge.
    logic [W-1:0] hist[$];
    logic [W-1:0] m_out;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    int           m_run[W];   // qualifying mismatch edges seen so far

    function automatic void model_edge(input logic rst, input logic tk,
                                       input logic [W-1:0] din);
        logic [W-1:0] sy;
        if (rst) begin
            hist.delete();
            for (int k = 0; k < D; k++) hist.push_back(RV);
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            return;
        end
        sy     = hist[0];
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < W; i++) begin
            if (sy[i] == m_out[i]) begin
                m_run[i] = 0;
            end else if (tk) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == F) begin
                    m_out[i] = sy[i];
                    if (sy[i]) m_rise[i] = 1'b1;
                    else       m_fall[i] = 1'b1;
                    m_run[i] = 0;
                end
            end
        end
        void'(hist.pop_front());
        hist.push_back(din);
    endfunction

    // One clock edge: model follows the inputs presented at the edge, outputs
    // are then stable for sampling 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge(reset, tick, data_in);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         rst;
        logic         tk;
        logic [W-1:0] din;
        logic [W-1:0] dout;
        logic [W-1:0] r;
        logic [W-1:0] f;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic tk, input logic [W-1:0] din,
                                input logic [W-1:0] dout, input logic [W-1:0] r,
                                input logic [W-1:0] f, input int n);
        vec_t v;
        v.rst = rst; v.tk = tk; v.din = din; v.dout = dout; v.r = r; v.f = f;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    initial begin
        logic [W-1:0] exp_r;
        logic [W-1:0] exp_d;
        logic [W-1:0] mask;
        int           hit;

        reset   = 1'b1;
        tick    = 1'b1;
        data_in = 8'h3D;

        // reset held 3 edges with data_in unrelated to RST_VAL
        add(1, 1, 8'h3D, RV,    8'h00, 8'h00, 3);
        add(0, 1, RV,    RV,    8'h00, 8'h00, 2);
        // ch0 0->1 before edge E (row 5): accepted at E+D-1+F = row 10
        add(0, 1, 8'hC3, RV,    8'h00, 8'h00, 5);
        add(0, 1, 8'hC3, 8'hC3, 8'h01, 8'h00, 1);
        add(0, 1, 8'hC3, 8'hC3, 8'h00, 8'h00, 1);
        // 3-cycle low glitch: rejected
        add(0, 1, RV,    8'hC3, 8'h00, 8'h00, 3);
        add(0, 1, 8'hC3, 8'hC3, 8'h00, 8'h00, 5);
        // 4-cycle low pulse: fall accepted, then rise once sy returns high
        add(0, 1, RV,    8'hC3, 8'h00, 8'h00, 4);
        add(0, 1, 8'hC3, 8'hC3, 8'h00, 8'h00, 1);
        add(0, 1, 8'hC3, RV,    8'h00, 8'h01, 1);
        add(0, 1, 8'hC3, RV,    8'h00, 8'h00, 3);
        add(0, 1, 8'hC3, 8'hC3, 8'h01, 8'h00, 1);
        add(0, 1, 8'hC3, 8'hC3, 8'h00, 8'h00, 1);
        // gated tick: mismatch seen from row 33; ticks at 33,36,38,39 -> fall at 39
        add(0, 0, RV,    8'hC3, 8'h00, 8'h00, 2);
        add(0, 1, RV,    8'hC3, 8'h00, 8'h00, 1);
        add(0, 0, RV,    8'hC3, 8'h00, 8'h00, 2);
        add(0, 1, RV,    8'hC3, 8'h00, 8'h00, 1);
        add(0, 0, RV,    8'hC3, 8'h00, 8'h00, 1);
        add(0, 1, RV,    8'hC3, 8'h00, 8'h00, 1);
        add(0, 1, RV,    RV,    8'h00, 8'h01, 1);
        add(0, 0, RV,    RV,    8'h00, 8'h00, 1);

        foreach (vecs[n]) begin
            reset   = vecs[n].rst;
            tick    = vecs[n].tk;
            data_in = vecs[n].din;
            step();
            check($sformatf("vec%0d data_out", n), data_out, vecs[n].dout);
            check($sformatf("vec%0d rise", n), rise, vecs[n].r);
            check($sformatf("vec%0d fall", n), fall, vecs[n].f);
            $display("vec %0d rst=%0b tick=%0b din=%h -> out=%h rise=%h fall=%h",
                     n, reset, tick, data_in, data_out, rise, fall);
        end

        // ---- reset mid-count: discard partial count, full latency afterwards ----
        tick    = 1'b1;
        data_in = 8'hC3;
        for (int k = 0; k < 4; k++) step();   // ch0 count reaches 2
        reset = 1'b1;
        step();
        check("midrst data_out", data_out, RV);
        check("midrst rise", rise, 8'h00);
        check("midrst fall", fall, 8'h00);
        reset = 1'b0;
        hit   = 0;
        for (int k = 1; k <= 20 && hit == 0; k++) begin
            step();
            if (data_out[0]) begin
                hit = k;
                check("midrst accept rise", rise, 8'h01);
            end else begin
                check("midrst pre-accept rise", rise, 8'h00);
            end
        end
        checks++;
        if (hit != D + F) begin
            errors++;
            $display("FAIL midrst latency: got %0d edges expected %0d", hit, D + F);
        end
        $display("midrst accepted after %0d edges", hit);

        // ---- channel independence ----
        reset   = 1'b1;
        data_in = RV;
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) step();
        data_in = RV | 8'h21;
        for (int k = 1; k <= 10; k++) begin
            if (k == 3) data_in = RV | 8'h29;
            step();
            exp_r = (k == 6) ? 8'h21 : (k == 8) ? 8'h08 : 8'h00;
            exp_d = (k < 6) ? RV : (k < 8) ? (RV | 8'h21) : (RV | 8'h29);
            check($sformatf("indep%0d rise", k), rise, exp_r);
            check($sformatf("indep%0d fall", k), fall, 8'h00);
            check($sformatf("indep%0d data_out", k), data_out, exp_d);
            $display("indep %0d din=%h -> out=%h rise=%h", k, data_in, data_out, rise);
        end

        // ---- randomized against the reference model ----
        for (int n = 0; n < 3000; n++) begin
            mask = '0;
            for (int i = 0; i < W; i++)
                if ($urandom_range(0, 5) == 0) mask[i] = 1'b1;
            data_in = data_in ^ mask;
            tick    = ($urandom_range(0, 3) != 0);
            reset   = ($urandom_range(0, 299) == 0);
            step();
            check("rand data_out", data_out, m_out);
            check("rand rise", rise, m_rise);
            check("rand fall", fall, m_fall);
            check("rand rise&fall", rise & fall, 8'h00);
            if (rise != 0 || fall != 0 || reset)
                $display("rand %0d rst=%0b tick=%0b din=%h -> out=%h rise=%h fall=%h",
                         n, reset, tick, data_in, data_out, rise, fall);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
